// File: rtl/axis_chirp_window_pkg.sv
// Shared widths, framer state encoding and arithmetic helpers for the chirp
// framer / windowing stage.
package axis_chirp_window_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int USER_WIDTH = 16;
    localparam int WIN_AW     = 12;
    localparam int COEF_FRAC  = 14;
    localparam int RAMP_W     = 18;
    localparam int NFFT_W     = 5;
    localparam int RCNT_W     = 16;
    localparam int PROD_W     = 2 * DATA_WIDTH + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } frm_state_e;

    // Clamp a wide signed product into the signed sample range.
    function automatic logic signed [DATA_WIDTH-1:0] sat16(input logic signed [PROD_W-1:0] v);
        logic signed [PROD_W-1:0] hi;
        logic signed [PROD_W-1:0] lo;
        hi = {{(PROD_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
        lo = ~hi;
        if (v > hi)
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (v < lo)
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            return v[DATA_WIDTH-1:0];
    endfunction

    function automatic logic [NFFT_W-1:0] clamp_nfft(input logic [NFFT_W-1:0] n);
        if (n == '0)
            return NFFT_W'(1);
        else if (n > NFFT_W'(WIN_AW))
            return NFFT_W'(WIN_AW);
        else
            return n;
    endfunction

endpackage

// File: rtl/axis_chirp_window_win_coef_ram.sv
// Simple dual-port window coefficient RAM: byte-enabled write port, registered
// read port. A colliding read sees the word as it was before the write.
module win_coef_ram
    import axis_chirp_window_pkg::*;
#(
    parameter int AW = WIN_AW,
    parameter int DW = DATA_WIDTH
) (
    input  logic            clk_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [DW-1:0]   wr_data_i,
    input  logic [DW/8-1:0] wr_be_i,
    input  logic            rd_en_i,
    input  logic [AW-1:0]   rd_addr_i,
    output logic [DW-1:0]   rd_data_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd_q;

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < DW/8; b++) begin
            if (wr_be_i[b])
                mem_q[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
        end
        if (rd_en_i)
            rd_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/axis_chirp_window.sv
// Chirp ramp timer, per-chirp AXI-Stream sample framer and a two-stage
// window multiply pipeline (RAM read, then multiply/saturate).
module axis_chirp_window
    import axis_chirp_window_pkg::*;
(
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [RAMP_W-1:0]       cfg_ramp,
    input  logic [NFFT_W-1:0]       cfg_nfft,
    output logic                    ramp_rq,
    output logic [RCNT_W-1:0]       ramp_cnt,
    output logic                    err_nsmall,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [USER_WIDTH-1:0]   m_axis_tuser,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    input  logic [WIN_AW-1:0]       win_addr,
    input  logic [DATA_WIDTH-1:0]   win_din,
    input  logic [DATA_WIDTH/8-1:0] win_we
);

    // ---------------- ramp timer ----------------
    logic [RAMP_W-1:0] rcnt_q, rcnt_d;
    logic              rq_q, rq_d;
    logic [RCNT_W-1:0] ccnt_q, ccnt_d;
    logic              hit;

    // Equality compare only: a period lowered below the count runs to the 2^18 wrap.
    assign hit = (cfg_ramp != '0) && (rcnt_q == cfg_ramp - RAMP_W'(1));

    always_comb begin
        rcnt_d = rcnt_q + RAMP_W'(1);
        rq_d   = hit;
        ccnt_d = ccnt_q;
        if (cfg_ramp == '0 || hit)
            rcnt_d = '0;
        if (hit)
            ccnt_d = ccnt_q + RCNT_W'(1);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rcnt_q <= '0;
            rq_q   <= 1'b0;
            ccnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
            rq_q   <= rq_d;
            ccnt_q <= ccnt_d;
        end
    end

    assign ramp_rq  = rq_q;
    assign ramp_cnt = ccnt_q;

    // ---------------- framer ----------------
    frm_state_e            st_q, st_d;
    logic [USER_WIDTH-1:0] idx_q, idx_d;
    logic [NFFT_W-1:0]     n_q, n_d;
    logic                  err_q, err_d;
    logic [USER_WIDTH-1:0] last_idx;
    logic                  is_last;
    logic                  adv;
    logic                  acc;
    logic                  v1_q, v2_q;

    assign adv           = m_axis_tready | ~v2_q;
    assign s_axis_tready = (st_q == FRAME) ? adv : 1'b1;
    assign acc           = s_axis_tvalid & s_axis_tready & (st_q == FRAME);
    assign last_idx      = (USER_WIDTH'(1) << n_q) - USER_WIDTH'(1);
    assign is_last       = (idx_q == last_idx);

    always_comb begin
        st_d  = st_q;
        idx_d = idx_q;
        n_d   = n_q;
        err_d = err_q;
        case (st_q)
            IDLE: begin
                if (rq_q) begin
                    st_d  = FRAME;
                    idx_d = '0;
                    n_d   = clamp_nfft(cfg_nfft);
                end
            end
            FRAME: begin
                // A request overlapping an open frame is flagged and dropped.
                if (rq_q)
                    err_d = 1'b1;
                if (acc) begin
                    idx_d = idx_q + USER_WIDTH'(1);
                    if (is_last) begin
                        st_d  = IDLE;
                        idx_d = '0;
                    end
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            st_q  <= IDLE;
            idx_q <= '0;
            n_q   <= NFFT_W'(1);
            err_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            idx_q <= idx_d;
            n_q   <= n_d;
            err_q <= err_d;
        end
    end

    assign err_nsmall = err_q;

    // ---------------- window multiply pipeline ----------------
    logic [DATA_WIDTH-1:0]        coef;
    logic signed [DATA_WIDTH-1:0] d1_q, d2_q;
    logic [USER_WIDTH-1:0]        u1_q, u2_q;
    logic                         l1_q, l2_q;
    logic signed [PROD_W-1:0]     prod;
    logic signed [PROD_W-1:0]     shifted;

    win_coef_ram #(
        .AW (WIN_AW),
        .DW (DATA_WIDTH)
    ) u_ram (
        .clk_i     (aclk),
        .wr_addr_i (win_addr),
        .wr_data_i (win_din),
        .wr_be_i   (win_we),
        .rd_en_i   (adv),
        .rd_addr_i (idx_q[WIN_AW-1:0]),
        .rd_data_o (coef)
    );

    // Coefficient is unsigned Q2.14: zero-extend before the signed multiply.
    assign prod    = PROD_W'(d1_q) * PROD_W'($signed({1'b0, coef}));
    assign shifted = prod >>> COEF_FRAC;

    always_ff @(posedge aclk) begin
        if (areset) begin
            v1_q <= 1'b0;
            d1_q <= '0;
            u1_q <= '0;
            l1_q <= 1'b0;
            v2_q <= 1'b0;
            d2_q <= '0;
            u2_q <= '0;
            l2_q <= 1'b0;
        end else if (adv) begin
            v1_q <= acc;
            if (acc) begin
                d1_q <= s_axis_tdata;
                u1_q <= idx_q;
                l1_q <= is_last;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                d2_q <= sat16(shifted);
                u2_q <= u1_q;
                l2_q <= l1_q;
            end
        end
    end

    assign m_axis_tvalid = v2_q;
    assign m_axis_tdata  = d2_q;
    assign m_axis_tuser  = u2_q;
    assign m_axis_tlast  = l2_q;

endmodule

// File: tb/tb_axis_chirp_window.sv
// Scoreboard bench for axis_chirp_window: a cycle model of the ramp timer and
// framer pushes expected windowed samples; the output monitor pops and compares.
module tb_axis_chirp_window;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [17:0] cfg_ramp = '0;
    logic [4:0]  cfg_nfft = 5'd10;
    logic        ramp_rq;
    logic [15:0] ramp_cnt;
    logic        err_nsmall;
    logic [15:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [15:0] m_axis_tdata;
    logic [15:0] m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic [11:0] win_addr = '0;
    logic [15:0] win_din = '0;
    logic [1:0]  win_we = '0;

    always #5 aclk = ~aclk;

    axis_chirp_window dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_ramp      (cfg_ramp),
        .cfg_nfft      (cfg_nfft),
        .ramp_rq       (ramp_rq),
        .ramp_cnt      (ramp_cnt),
        .err_nsmall    (err_nsmall),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .win_addr      (win_addr),
        .win_din       (win_din),
        .win_we        (win_we)
    );

    typedef struct {
        logic [15:0] data;
        logic [15:0] user;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int errs = 0;
    int checks = 0;

    // next-cycle drive values, applied at the falling edge inside step()
    logic        rst_nx = 1'b1;
    logic [17:0] ramp_nx = '0;
    logic [4:0]  nfft_nx = 5'd10;
    logic [11:0] addr_nx = '0;
    logic [15:0] din_nx = '0;
    logic [1:0]  we_nx = '0;
    int          in_mode = 0;
    int          rdy_mode = 0;
    int          dat_mode = 0;
    logic [15:0] const_val = '0;

    // reference model state
    int          cyc = 0;
    bit          m_frame, m_err, m_rq, rst_prev, hold_v;
    int          m_idx, m_n, m_cnt, m_rcnt, pop_cnt, nlast, exp_len;
    bit          hann_chk = 0, sat_chk = 0, saw_stall = 0;
    logic [15:0] coef_m [4096];
    logic [15:0] hd, hu;
    logic        hl;

    task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_win(input logic [15:0] s, input logic [15:0] c);
        longint p;
        p = longint'($signed(s)) * longint'(c);
        p = p >>> 14;
        if (p > 32767) p = 32767;
        else if (p < -32768) p = -32768;
        return p[15:0];
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_rq = 0; m_rcnt = 0;
        m_frame = 0; m_idx = 0; m_err = 0;
        hold_v = 0; pop_cnt = 0; nlast = 0;
        sb.delete();
    endtask

    task automatic model_eval();
        exp_t e;
        bit   fr0, acc, hit;
        check("ramp_rq", ramp_rq, m_rq);
        check("err_nsmall", err_nsmall, m_err);
        if (m_rq) check("ramp_cnt", ramp_cnt, m_rcnt);
        if (!m_frame) check("tready_idle", s_axis_tready, 1);
        else if (!s_axis_tready) saw_stall = 1;
        if (hold_v) begin
            check("stall_tvalid", m_axis_tvalid, 1);
            check("stall_tdata", m_axis_tdata, hd);
            check("stall_tuser", m_axis_tuser, hu);
            check("stall_tlast", m_axis_tlast, hl);
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0) begin
                check("spurious_out", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("tdata", $signed(m_axis_tdata), $signed(e.data));
                check("tuser", m_axis_tuser, e.user);
                check("tlast", m_axis_tlast, e.last);
                if (rdy_mode == 0) check("latency", cyc - e.cyc, 2);
                if (hann_chk && e.user == 0) check("hann_idx0", $signed(m_axis_tdata), 0);
                if (hann_chk && e.user == 512) check("hann_idx512", $signed(m_axis_tdata), 8191);
                if (sat_chk) check("sat_neg", $signed(m_axis_tdata), -32768);
                pop_cnt++;
                if (m_axis_tlast) begin
                    check("frame_len", pop_cnt, exp_len);
                    pop_cnt = 0;
                    nlast++;
                end
            end
        end
        hold_v = m_axis_tvalid && !m_axis_tready;
        hd = m_axis_tdata; hu = m_axis_tuser; hl = m_axis_tlast;

        fr0 = m_frame;
        acc = s_axis_tvalid && s_axis_tready;
        if (fr0 && acc) begin
            e.data = ref_win(s_axis_tdata, coef_m[m_idx]);
            e.user = 16'(m_idx);
            e.last = (m_idx == (1 << m_n) - 1);
            e.cyc  = cyc;
            sb.push_back(e);
            if (e.last) begin m_frame = 0; m_idx = 0; end
            else m_idx++;
        end
        if (m_rq) begin
            if (!fr0) begin
                m_frame = 1; m_idx = 0;
                m_n = int'(cfg_nfft);
                if (m_n == 0) m_n = 1;
                if (m_n > 12) m_n = 12;
            end else begin
                m_err = 1;
            end
        end
        hit = (cfg_ramp != 0) && (m_cnt == int'(cfg_ramp) - 1);
        m_cnt = (cfg_ramp == 0 || hit) ? 0 : ((m_cnt + 1) & 32'h3ffff);
        m_rq = hit;
        if (hit) m_rcnt = (m_rcnt + 1) & 32'hffff;
    endtask

    // One clock: drive at the falling edge, then model the coming rising edge.
    task automatic step();
        @(negedge aclk);
        areset   = rst_nx;
        cfg_ramp = ramp_nx;
        cfg_nfft = nfft_nx;
        win_addr = addr_nx;
        win_din  = din_nx;
        win_we   = we_nx;
        case (in_mode)
            0: s_axis_tvalid = 1'b0;
            1: s_axis_tvalid = 1'b1;
            2: s_axis_tvalid = cyc[0];
            default: s_axis_tvalid = ($urandom_range(0, 1) == 1);
        endcase
        s_axis_tdata  = dat_mode ? 16'($urandom) : const_val;
        m_axis_tready = rdy_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        #1;
        if (rst_prev) check("rst_tvalid", m_axis_tvalid, 0);
        if (areset) model_reset();
        else model_eval();
        rst_prev = areset;
        if (win_we[0]) coef_m[win_addr][7:0]  = win_din[7:0];
        if (win_we[1]) coef_m[win_addr][15:8] = win_din[15:8];
        cyc++;
    endtask

    task automatic do_reset();
        rst_nx = 1'b1;
        step();
        step();
        check("rst_tvalid_q", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_ramp_rq", ramp_rq, 0);
        check("rst_ramp_cnt", ramp_cnt, 0);
        check("rst_err", err_nsmall, 0);
        check("rst_tready", s_axis_tready, 1);
        rst_nx = 1'b0;
    endtask

    task automatic run_and_close(input int n, input int frames);
        repeat (n) step();
        check("drain", sb.size(), 0);
        check("frames", nlast, frames);
    endtask

    initial begin
        model_reset();
        // load a Hann window for the first 1024 entries with requests disabled
        do_reset();
        for (int i = 0; i < 1024; i++) begin
            real w;
            w = 8192.0 * (1.0 - $cos(2.0 * 3.14159265358979 * i / 1024.0));
            addr_nx = 12'(i);
            din_nx  = 16'($rtoi(w + 0.5));
            we_nx   = 2'b11;
            step();
        end
        we_nx = 2'b00;

        // ramp period 62500, random data framed at 1024
        ramp_nx = 18'd62500; nfft_nx = 5'd10; exp_len = 1024;
        in_mode = 1; dat_mode = 1; rdy_mode = 0;
        do_reset();
        repeat (62500) step();
        check("rq_early", ramp_rq, 0);
        step();
        check("rq_first", ramp_rq, 1);
        check("rq_cnt1", ramp_cnt, 1);
        step();
        check("rq_width", ramp_rq, 0);
        run_and_close(1100, 1);

        // Hann window with constant 8191
        ramp_nx = 18'd1500; dat_mode = 0; const_val = 16'd8191; hann_chk = 1;
        do_reset();
        run_and_close(2600, 1);
        hann_chk = 0;

        // byte-lane writes, then random data under 50% backpressure
        in_mode = 0;
        addr_nx = 12'd5; din_nx = 16'h1234; we_nx = 2'b01; step();
        addr_nx = 12'd6; din_nx = 16'hABCD; we_nx = 2'b10; step();
        we_nx = 2'b00;
        ramp_nx = 18'd3000; in_mode = 1; dat_mode = 1; rdy_mode = 1; saw_stall = 0;
        do_reset();
        run_and_close(5400, 1);
        check("saw_stall", saw_stall, 1);
        rdy_mode = 0;

        // nfft=0 clamps to 2-sample frames, random input valid
        ramp_nx = 18'd20; nfft_nx = 5'd0; exp_len = 2; in_mode = 3;
        do_reset();
        run_and_close(200, 9);

        // saturation: coef 0xFFFF with -32768
        in_mode = 0;
        for (int i = 0; i < 8; i++) begin
            addr_nx = 12'(i); din_nx = 16'hFFFF; we_nx = 2'b11; step();
        end
        we_nx = 2'b00;
        ramp_nx = 18'd30; nfft_nx = 5'd3; exp_len = 8; in_mode = 1;
        dat_mode = 0; const_val = 16'h8000; sat_chk = 1;
        do_reset();
        run_and_close(110, 3);
        sat_chk = 0;

        // overlapping request: period 500, 1024 frame at half input rate
        ramp_nx = 18'd500; nfft_nx = 5'd10; exp_len = 1024; in_mode = 2; dat_mode = 1;
        do_reset();
        repeat (1001) step();
        check("err_before_2nd", err_nsmall, 0);
        step();
        check("err_at_2nd", err_nsmall, 1);
        run_and_close(1698, 1);
        check("err_sticky", err_nsmall, 1);
        repeat (500) step();
        check("frame2_open", m_frame, 1);
        rst_nx = 1'b1;
        step();
        rst_nx = 1'b0;
        step();
        check("midrst_tvalid", m_axis_tvalid, 0);
        check("midrst_err", err_nsmall, 0);
        check("midrst_tlast", m_axis_tlast, 0);
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/axis_chirp_window.md
# axis_chirp_window

Per-chirp sample framer and windowing stage for the FMCW receive path. A ramp timer emits one request per chirp period. On each request the framer cuts the next 2^cfg_nfft ADC samples into an AXI-Stream frame, tagging each sample with its index. The multiplier then scales every sample by a host-loaded window coefficient before the FFT.

## Interface
- DATA_WIDTH, 16, sample and coefficient width
- USER_WIDTH, 16, tuser (sample index) width
- WIN_AW, 12, window RAM address width (max frame 4096)
- COEF_FRAC, 14, fractional bits of window coefficient
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- cfg_ramp  in  18  chirp period in aclk cycles; 0 disables requests
- cfg_nfft  in  5  log2 frame length, clamped to 1..WIN_AW
- ramp_rq  out  1  one-cycle chirp request pulse
- ramp_cnt  out  16  chirp counter, wraps
- err_nsmall  out  1  sticky: request arrived while a frame was still open
- s_axis_tdata  in  16  signed ADC sample
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  16  signed windowed sample
- m_axis_tuser  out  16  sample index within frame
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last sample of frame
- m_axis_tready  in  1  downstream ready
- win_addr  in  12  coefficient write address
- win_din  in  16  coefficient (unsigned, Q2.14)
- win_we  in  2  byte write enables ([1]=high byte)

## Operation
- Ramp timer:
  - Counter runs 0..cfg_ramp-1.
  - ramp_rq pulses in the cycle the counter equals cfg_ramp-1; the counter then returns to 0.
  - ramp_cnt increments on each pulse.
- Framer states:
  - IDLE: s_axis_tready=1. Samples are accepted and discarded. ramp_rq moves to FRAME with idx=0.
  - FRAME: s_axis_tready follows the multiplier's input ready. Each accepted sample is forwarded with tuser=idx, and idx is incremented. tlast is set when idx=2^N-1; after that sample the framer returns to IDLE.
  - ramp_rq while in FRAME sets err_nsmall and is otherwise ignored; the current frame completes.
  - N is the clamped cfg_nfft, sampled at frame start.
- Window RAM:
  - 2^WIN_AW x 16.
  - Write port: win_we per byte lane; writes are independent of streaming.
  - Read port: addressed by sample tuser[WIN_AW-1:0].
  - A same-address read/write in one cycle returns the old word.
- Multiply: out = sat16((sample_signed * coef_unsigned) >>> COEF_FRAC).
  - The product is 33 bits signed.
  - Arithmetic shift, truncating toward -inf.
  - Saturation to +32767 / -32768.
- tuser and tlast travel with the data through the pipeline unchanged.

## Timing
- Reset:
  - Ramp counter is 0, ramp_cnt is 0, ramp_rq is 0.
  - Framer is in IDLE, idx is 0, err_nsmall is 0.
  - The multiplier pipeline is empty: m_axis_tvalid, tlast and tdata are all 0.
  - RAM contents are undefined and retained.
- Mid-frame reset: the frame is aborted with no tlast emitted.
- Ramp timing: with cfg_ramp=P, the first ramp_rq occurs P cycles after reset release, then every P cycles.
  - A change of cfg_ramp takes effect at the next compare.
  - If P is lowered below the current count, the counter wraps at 2^18.
- ramp_rq → FRAME in the next cycle. The first sample accepted in that cycle or later gets index 0.
- Multiplier latency: 2 cycles from input handshake to m_axis_tvalid (stage 1: RAM read; stage 2: multiply and saturate), with no downstream stall.
  - The pipeline advances when m_axis_tready=1 or its output stage is empty.
  - Input ready = advance condition; full throughput is 1 sample/cycle.
- AXIS rules:
  - tdata, tuser and tlast stay stable while tvalid=1 and tready=0.
  - tvalid does not depend combinationally on tready.

## Structure
- Shared package: DATA_WIDTH, USER_WIDTH, WIN_AW, COEF_FRAC, framer state enum (IDLE, FRAME), and the sat16 function.
- One natural sub-module: win_coef_ram, a simple dual-port RAM with byte enables and registered read.
- The timer, framer and multiply pipeline stay in the top.

## Test plan
- Ramp timer: areset then release with cfg_ramp=62500 → ramp_rq pulses 1 cycle wide at cycles 62500, 125000, …; ramp_cnt becomes 1, 2, ….
- Framing: cfg_nfft=10, continuous input, m_axis_tready=1 → exactly 1024 outputs per request with tuser 0..1023, tlast only at 1023. Samples outside frames are dropped.
- Windowing, Hann table: load a Hann table (Q2.14, peak 16384 at index 512) and feed constant 8191 → outputs are 0 at idx 0 and 8191 at idx 512.
- Windowing, saturation: coef 0xFFFF with sample -32768 → output -32768.
- Backpressure: toggle m_axis_tready 50%. No samples are lost or duplicated, data is stable while stalled, and s_axis_tready drops within the frame.
- err_nsmall: cfg_ramp=500 with cfg_nfft=10 and 1 sample per 2 cycles → err_nsmall=1 at the second request, and the first frame still ends with tlast at 1023. Reset clears err_nsmall; a reset asserted mid-frame clears m_axis_tvalid on the next cycle.
